// File: rtl/button_event_arbiter.sv
// Round-robin arbiter that serialises per-button press pulses into an ordered
// show-ahead event FIFO with a valid/ready handshake and a saturating drop counter.
module button_event_arbiter #(
   parameter  int N_BTN      = 4,
   parameter  int FIFO_DEPTH = 4,
   parameter  int CNT_W      = 8,
   localparam int IDW        = (N_BTN > 1) ? $clog2(N_BTN) : 1,
   localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] pulse_in,
   input  logic             evt_ready,
   input  logic             clear_drops,
   output logic             evt_valid,
   output logic [IDW-1:0]   evt_id,
   output logic [N_BTN-1:0] pending,
   output logic [LW-1:0]    fifo_level,
   output logic [CNT_W-1:0] drop_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(N_BTN + 1);
   localparam int SW = CNT_W + CW;
   localparam logic [LW-1:0]    FULL_LVL = LW'(FIFO_DEPTH);
   localparam logic [IDW-1:0]   LAST_ID  = IDW'(N_BTN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [IDW:0]     N_EXT    = (IDW + 1)'(N_BTN);

   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   winner;
   logic [IDW-1:0]   rr_next;
   logic             grant_vld;
   logic [N_BTN-1:0] grant_oh;
   logic [N_BTN-1:0] drop_bits;
   logic [N_BTN-1:0] pending_next;
   logic             pop;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [IDW-1:0]   fifo_mem [FIFO_DEPTH];

   function automatic logic [CW-1:0] popcount(input logic [N_BTN-1:0] v);
      logic [CW-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < N_BTN; i++) begin
         cnt = cnt + CW'(v[i]);
      end
      return cnt;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CW-1:0]    b);
      logic [SW-1:0] sum;
      sum = SW'(a) + SW'(b);
      if (sum > SW'(CNT_MAX)) begin
         return CNT_MAX;
      end
      return sum[CNT_W-1:0];
   endfunction

   // Grant stage: first pending requester at or after rr_ptr, wrapping at N_BTN-1.
   always_comb begin : grant_search
      logic         found;
      logic [IDW:0] idx_ext;
      found     = 1'b0;
      winner    = '0;
      grant_oh  = '0;
      idx_ext   = '0;
      for (int k = 0; k < N_BTN; k++) begin
         idx_ext = {1'b0, rr_ptr} + (IDW + 1)'(k);
         if (idx_ext >= N_EXT) begin
            idx_ext = idx_ext - N_EXT;
         end
         if (!found && pending[idx_ext[IDW-1:0]]) begin
            found  = 1'b1;
            winner = idx_ext[IDW-1:0];
         end
      end
      // Space is judged on the registered level only; a same-cycle pop does not count.
      grant_vld = found && (fifo_level < FULL_LVL);
      if (grant_vld) begin
         grant_oh[winner] = 1'b1;
      end
   end

   always_comb begin
      rr_next      = (winner == LAST_ID) ? '0 : winner + IDW'(1);
      drop_bits    = pulse_in & pending & ~grant_oh;
      pending_next = (pending & ~grant_oh) | pulse_in;
      evt_valid    = (fifo_level != '0);
      pop          = evt_valid & evt_ready;
      evt_id       = evt_valid ? fifo_mem[rd_ptr] : '0;
   end

   // Control state: pending flags, round-robin pointer, FIFO pointers and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending    <= '0;
         rr_ptr     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         drop_count <= '0;
      end else begin
         pending <= pending_next;
         if (grant_vld) begin
            rr_ptr <= rr_next;
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({grant_vld, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (clear_drops) begin
            drop_count <= '0;
         end else begin
            drop_count <= sat_add(drop_count, popcount(drop_bits));
         end
      end
   end

   // FIFO storage: data only, validity is tracked by fifo_level.
   always_ff @(posedge clk) begin
      if (grant_vld) begin
         fifo_mem[wr_ptr] <= winner;
      end
   end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter (8 buttons, 4-deep FIFO, 2-bit drop counter).
module tb_button_event_arbiter;

   localparam int N_BTN      = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pulse_in = '0;
   logic       evt_ready = 1'b0;
   logic       clear_drops = 1'b0;
   logic       evt_valid;
   logic [2:0] evt_id;
   logic [7:0] pending;
   logic [2:0] fifo_level;
   logic [1:0] drop_count;

   int checks = 0;
   int errors = 0;

   button_event_arbiter #(
      .N_BTN(N_BTN), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .pulse_in(pulse_in), .evt_ready(evt_ready),
      .clear_drops(clear_drops), .evt_valid(evt_valid), .evt_id(evt_id),
      .pending(pending), .fifo_level(fifo_level), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_valid",   32'(evt_valid),  32'd0);
      chk("rst_id",      32'(evt_id),     32'd0);
      chk("rst_pending", 32'(pending),    32'd0);
      chk("rst_level",   32'(fifo_level), 32'd0);
      chk("rst_drops",   32'(drop_count), 32'd0);
      rst = 1'b0;

      // 1: single press, latency 2
      pulse_in = 8'h04;
      tick();
      pulse_in = 8'h00;
      chk("t1_pend_e0",  32'(pending),   32'h04);
      chk("t1_valid_e0", 32'(evt_valid), 32'd0);
      tick();
      chk("t1_valid_e1", 32'(evt_valid),  32'd1);
      chk("t1_id_e1",    32'(evt_id),     32'd2);
      chk("t1_level_e1", 32'(fifo_level), 32'd1);
      chk("t1_pend_e1",  32'(pending),    32'h00);
      evt_ready = 1'b1;
      tick();
      chk("t1_level_pop", 32'(fifo_level), 32'd0);
      chk("t1_valid_pop", 32'(evt_valid),  32'd0);

      // 2: fairness from rr_ptr=0, twice, then from rr_ptr=2
      do_reset();
      for (int rep = 0; rep < 2; rep++) begin
         pulse_in = 8'h0F;
         tick();
         pulse_in = 8'h00;
         for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t2_order_r%0d_%0d", rep, k), 32'(evt_id), 32'(k));
            chk($sformatf("t2_valid_r%0d_%0d", rep, k), 32'(evt_valid), 32'd1);
         end
         tick();
         chk($sformatf("t2_empty_r%0d", rep), 32'(evt_valid), 32'd0);
      end
      pulse_in = 8'h02;
      tick();
      pulse_in = 8'h00;
      tick();
      chk("t2_rr_setup_id", 32'(evt_id), 32'd1);
      tick();
      chk("t2_rr_setup_empty", 32'(fifo_level), 32'd0);
      pulse_in = 8'h0F;
      tick();
      pulse_in = 8'h00;
      begin
         logic [2:0] exp_rr [4];
         exp_rr[0] = 3'd2; exp_rr[1] = 3'd3; exp_rr[2] = 3'd0; exp_rr[3] = 3'd1;
         for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t2_rr2_%0d", k), 32'(evt_id), 32'(exp_rr[k]));
         end
      end
      tick();
      chk("t2_rr2_empty", 32'(evt_valid), 32'd0);

      // 3: backpressure and full FIFO
      do_reset();
      evt_ready = 1'b0;
      pulse_in = 8'h1F;
      tick();
      pulse_in = 8'h00;
      for (int k = 0; k < 5; k++) tick();
      chk("t3_level_full", 32'(fifo_level), 32'd4);
      chk("t3_pend_left",  32'(pending),    32'h10);
      chk("t3_head_hold",  32'(evt_id),     32'd0);
      chk("t3_no_drop",    32'(drop_count), 32'd0);
      pulse_in = 8'h10;
      tick();
      pulse_in = 8'h00;
      chk("t3_drop_one",  32'(drop_count), 32'd1);
      chk("t3_pend_hold", 32'(pending),    32'h10);
      chk("t3_head_hold2", 32'(evt_id),    32'd0);
      evt_ready = 1'b1;
      tick();
      chk("t3_lvl_pop_full", 32'(fifo_level), 32'd3);
      chk("t3_deliver_1",    32'(evt_id),     32'd1);
      for (int k = 2; k < 5; k++) begin
         tick();
         chk($sformatf("t3_deliver_%0d", k), 32'(evt_id), 32'(k));
      end
      tick();
      chk("t3_drained", 32'(evt_valid), 32'd0);
      chk("t3_pend_0",  32'(pending),   32'h00);

      // 4: press during own grant
      do_reset();
      evt_ready = 1'b1;
      pulse_in = 8'h02;
      tick();
      tick();
      pulse_in = 8'h00;
      chk("t4_pend_requeue", 32'(pending),    32'h02);
      chk("t4_first_id",     32'(evt_id),     32'd1);
      tick();
      chk("t4_second_valid", 32'(evt_valid),  32'd1);
      chk("t4_second_id",    32'(evt_id),     32'd1);
      chk("t4_pend_clear",   32'(pending),    32'h00);
      tick();
      chk("t4_empty",        32'(evt_valid),  32'd0);
      chk("t4_no_drop",      32'(drop_count), 32'd0);

      // 5: popcount, saturation, clear priority
      do_reset();
      evt_ready = 1'b0;
      pulse_in = 8'hFF;
      tick();
      pulse_in = 8'h00;
      for (int k = 0; k < 4; k++) tick();
      chk("t5_pend_f0", 32'(pending), 32'hF0);
      pulse_in = 8'h30;
      tick();
      chk("t5_drop_2", 32'(drop_count), 32'd2);
      pulse_in = 8'h10;
      tick();
      chk("t5_drop_3", 32'(drop_count), 32'd3);
      tick();
      chk("t5_sat_a", 32'(drop_count), 32'd3);
      tick();
      chk("t5_sat_b", 32'(drop_count), 32'd3);
      clear_drops = 1'b1;
      tick();
      clear_drops = 1'b0;
      pulse_in = 8'h00;
      chk("t5_clear_prio", 32'(drop_count), 32'd0);

      // 6: asynchronous reset between edges
      do_reset();
      evt_ready = 1'b0;
      pulse_in = 8'h1F;
      tick();
      pulse_in = 8'h00;
      tick();
      tick();
      pulse_in = 8'h10;
      tick();
      pulse_in = 8'h00;
      chk("t6_pre_level", 32'(fifo_level), 32'd3);
      chk("t6_pre_pend",  32'(pending),    32'h18);
      chk("t6_pre_drop",  32'(drop_count), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_valid", 32'(evt_valid),  32'd0);
      chk("t6_async_level", 32'(fifo_level), 32'd0);
      chk("t6_async_pend",  32'(pending),    32'h00);
      chk("t6_async_drop",  32'(drop_count), 32'd0);
      chk("t6_async_id",    32'(evt_id),     32'd0);
      tick();
      rst = 1'b0;
      pulse_in = 8'h08;
      tick();
      pulse_in = 8'h00;
      chk("t6_post_e0_valid", 32'(evt_valid), 32'd0);
      tick();
      chk("t6_post_e1_valid", 32'(evt_valid), 32'd1);
      chk("t6_post_e1_id",    32'(evt_id),    32'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
